mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares a single data/instruction memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of a multi-cycle CPU. It sits between the fetch/datapath logic and the memory block. It grants one transaction at a time and forwards it to memory as a one-cycle strobe. For reads, it waits a fixed memory latency and returns the data to the owner with a one-cycle valid pulse. LSU has priority; a starvation guard guarantees fetch progress.

## Interface
Parameters:
- MEM_LATENCY, 2: cycles from the mem_en cycle to the cycle in which mem_rdata is valid; legal range is 1..15.
- STARVE_LIMIT, 4: number of consecutive LSU grants that may be given while IFU is waiting before IFU is forced first; legal range is 1..15.

Ports:
- SYS_clk  in  1  system clock; every register updates on the rising edge.
- SYS_reset  in  1  synchronous reset, active-low: 0 at a rising edge resets the block.
- ifu_req  in  1  fetch request; held with ifu_addr until ifu_gnt is seen.
- ifu_addr  in  32  fetch address; the access is always a word, unsigned.
- ifu_gnt  out  1  one-cycle grant pulse to IFU.
- ifu_rvalid  out  1  one-cycle pulse; ifu_rdata is valid while it is high.
- ifu_rdata  out  32  fetched word.
- lsu_req  in  1  load/store request; held with its payload until lsu_gnt is seen.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_length  in  2  access size: 01 byte, 10 half, 11 word.
- lsu_signed  in  1  sign-extend loads.
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store data.
- lsu_gnt  out  1  one-cycle grant pulse to LSU.
- lsu_rvalid  out  1  one-cycle pulse on load completion; stores produce none.
- lsu_rdata  out  32  load data, already extended by memory.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write strobe; only meaningful while mem_en=1.
- mem_length  out  2  size forwarded to memory; 11 for fetches.
- mem_signed  out  1  forwarded signedness; 0 for fetches.
- mem_addr  out  32  access address.
- mem_wdata  out  32  store data; 0 on reads.
- mem_rdata  in  32  read data, valid MEM_LATENCY cycles after mem_en.
- busy  out  1  high in every state except IDLE and DONE.

## Operation
- States:
  - IDLE: arbitrates.
  - ISSUE: mem_en=1 for exactly one cycle.
  - WAIT: a latency counter runs.
  - DONE: rvalid pulse; arbitrates exactly like IDLE.
- Arbitration in IDLE or DONE:
  - Only one requester active: it wins.
  - Both active: LSU wins unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
- starve_cnt:
  - Increments on each LSU grant made while ifu_req=1, saturating at STARVE_LIMIT.
  - Clears to 0 on any IFU grant, or on an LSU grant made with ifu_req=0.
- On a grant:
  - The winner's payload is latched into the mem_* registers, together with an owner bit.
  - gnt pulses and the state becomes ISSUE.
  - No request: stay in or return to IDLE; outputs hold, with mem_en=0.
- Leaving ISSUE:
  - Store: go to IDLE.
  - Read (fetch or load): go to WAIT and load wait_cnt with MEM_LATENCY-1.
- WAIT:
  - Decrements wait_cnt each cycle.
  - In the cycle wait_cnt==0, mem_rdata is sampled into the owner's rdata register and the next state is DONE.
  - With MEM_LATENCY=1, WAIT lasts exactly one cycle.
- DONE:
  - Owner's rvalid=1 for one cycle; the other rvalid stays 0.
  - rdata holds its value until the next read by the same owner completes.
- Requests are ignored in ISSUE and WAIT. A requester holding req is not a protocol error; it is serviced in the next IDLE/DONE.
- Exactly one transaction is outstanding at a time; ifu_gnt and lsu_gnt are never high together.
- No alignment or length checking: lsu_length=00 is forwarded unchanged (memory performs no write), and the transaction completes normally.
- Reset (SYS_reset=0 at an edge), including mid-transaction:
  - State becomes IDLE; starve_cnt, wait_cnt and the owner bit clear.
  - Every output clears to 0, including rdata and mem_length.
  - A pending read is abandoned and produces no rvalid.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Read with req first seen at cycle 0 in IDLE:
  - gnt and mem_en in cycle 1.
  - mem_rdata valid in cycle 1+MEM_LATENCY.
  - rvalid/rdata in cycle 2+MEM_LATENCY.
  - Next grant is possible in cycle 3+MEM_LATENCY (arbitration in DONE).
- Store: gnt, mem_en and mem_we in cycle 1; IDLE in cycle 2; next grant is possible in cycle 3.
- The requester drops or changes req at the edge after seeing gnt; a req still high during ISSUE is harmless.
- Throughput: one read per MEM_LATENCY+2 cycles; one store per 2 cycles.

## Test plan
- Reset: hold SYS_reset=0 for 2 cycles with both reqs high -> every output is 0, no gnt; after release, lsu_gnt in the first cycle.
- Single fetch, MEM_LATENCY=2: ifu_req with addr 0x0000_0100 at cycle 0; memory returns 0x0000_0513 -> ifu_gnt, mem_en, mem_length=11 at cycle 1; ifu_rvalid with ifu_rdata=0x0000_0513 at cycle 4.
- Store: lsu_we=1, length=01, addr 0x200, wdata 0xAB -> one cycle with mem_en=mem_we=1, mem_addr=0x200, mem_wdata=0xAB, mem_length=01; no lsu_rvalid; IDLE at the following cycle.
- Starvation, STARVE_LIMIT=4: both reqs held high continuously -> grant order L,L,L,L,I,L,L,L,L,I; gnt signals are never simultaneous.
- Reset during WAIT: assert SYS_reset=0 one cycle after mem_en of a load -> no lsu_rvalid ever; the next request is granted normally after release.
- MEM_LATENCY=1 back-to-back loads -> lsu_rvalid every 3 cycles; data matches memory per address.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (IFU/LSU) and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_length;
    logic        lsu_signed;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_length;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  ifu_req, ifu_addr, lsu_req, lsu_we, lsu_length, lsu_signed, lsu_addr, lsu_wdata, mem_rdata,
        output ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_en, mem_we, mem_length, mem_signed, mem_addr, mem_wdata, busy
    );

    modport master (
        output ifu_req, ifu_addr, lsu_req, lsu_we, lsu_length, lsu_signed, lsu_addr, lsu_wdata, mem_rdata,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_en, mem_we, mem_length, mem_signed, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU, LSU-first with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               SYS_clk,
    input logic               SYS_reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_starve;
    logic [3:0]  r_wait;
    logic        r_owner_lsu;
    logic        r_ifu_gnt, r_lsu_gnt, r_ifu_rvalid, r_lsu_rvalid;
    logic        r_mem_en, r_mem_we, r_mem_signed, r_busy;
    logic [1:0]  r_mem_length;
    logic [31:0] r_ifu_rdata, r_lsu_rdata, r_mem_addr, r_mem_wdata;
    logic        w_arb, w_take_ifu, w_take_lsu;

    assign w_arb      = (r_state == IDLE) || (r_state == DONE);
    assign w_take_ifu = w_arb && bus.ifu_req && (!bus.lsu_req || r_starve == LIMIT);
    assign w_take_lsu = w_arb && bus.lsu_req && !w_take_ifu;

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            r_state      <= IDLE;
            r_starve     <= '0;
            r_wait       <= '0;
            r_owner_lsu  <= 1'b0;
            r_ifu_gnt    <= 1'b0;
            r_lsu_gnt    <= 1'b0;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_signed <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_length <= '0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_ifu_gnt    <= w_take_ifu;
            r_lsu_gnt    <= w_take_lsu;
            r_mem_en     <= w_take_ifu || w_take_lsu;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= (w_take_ifu || w_take_lsu) ? ISSUE : IDLE;
                    r_busy  <= w_take_ifu || w_take_lsu;
                    if (w_take_ifu) begin
                        r_owner_lsu  <= 1'b0;
                        r_starve     <= '0;
                        r_mem_we     <= 1'b0;
                        r_mem_length <= 2'b11;
                        r_mem_signed <= 1'b0;
                        r_mem_addr   <= bus.ifu_addr;
                        r_mem_wdata  <= '0;
                    end else if (w_take_lsu) begin
                        r_owner_lsu  <= 1'b1;
                        // Only LSU wins taken while IFU is waiting count toward starvation.
                        r_starve     <= !bus.ifu_req ? '0 : (r_starve == LIMIT) ? r_starve : r_starve + 4'd1;
                        r_mem_we     <= bus.lsu_we;
                        r_mem_length <= bus.lsu_length;
                        r_mem_signed <= bus.lsu_signed;
                        r_mem_addr   <= bus.lsu_addr;
                        r_mem_wdata  <= bus.lsu_we ? bus.lsu_wdata : '0;
                    end
                end
                ISSUE: begin
                    r_state <= r_mem_we ? IDLE : WAIT;
                    r_busy  <= !r_mem_we;
                    r_wait  <= LAT_M1;
                end
                WAIT: begin
                    if (r_wait == '0) begin
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_ifu_rvalid <= !r_owner_lsu;
                        r_lsu_rvalid <= r_owner_lsu;
                        if (r_owner_lsu) r_lsu_rdata <= bus.mem_rdata;
                        else r_ifu_rdata <= bus.mem_rdata;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ifu_gnt    = r_ifu_gnt;
    assign bus.ifu_rvalid = r_ifu_rvalid;
    assign bus.ifu_rdata  = r_ifu_rdata;
    assign bus.lsu_gnt    = r_lsu_gnt;
    assign bus.lsu_rvalid = r_lsu_rvalid;
    assign bus.lsu_rdata  = r_lsu_rdata;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_length = r_mem_length;
    assign bus.mem_signed = r_mem_signed;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.busy       = r_busy;
endmodule
